seq_restoring_div_nbit: RTL and testbench



---
 rtl/seq_restoring_div_nbit.sv | 180 ++++++++++++++++++
 tb/tb_seq_restoring_div_nbit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_div_nbit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, built on an
// n-bit ripple-borrow subtractor. Optional macro: DIV_ZERO_CHECK_EN (zero-divisor fast path).

module sub_ripple_borrow_nbit #(
    parameter int NUM_BIT = 8
) (
    input  logic [NUM_BIT-1:0] a,
    input  logic [NUM_BIT-1:0] b,
    input  logic               bin,
    output logic [NUM_BIT-1:0] diff,
    output logic               bout
);
    logic [NUM_BIT:0] borrow;

    assign borrow[0] = bin;

    generate
        for (genvar gi = 0; gi < NUM_BIT; gi++) begin : g_bit
            assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
            assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
        end
    endgenerate

    assign bout = borrow[NUM_BIT];
endmodule

module seq_restoring_div_nbit #(
    parameter int NUM_BIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_BIT-1:0] dividend,
    input  logic [NUM_BIT-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [NUM_BIT-1:0] quotient,
    output logic [NUM_BIT-1:0] remainder,
    output logic               div_by_zero
);
    localparam int CW = (NUM_BIT > 1) ? $clog2(NUM_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_BIT-1:0] pr_q, pr_d;
    logic [NUM_BIT-1:0] dvs_q, dvs_d;
    logic [NUM_BIT-1:0] dvd_q, dvd_d;
    logic [NUM_BIT-1:0] quotient_q, quotient_d;
    logic [NUM_BIT-1:0] remainder_q, remainder_d;

    // dvd_q doubles as the quotient accumulator: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    logic [NUM_BIT:0]   shifted;
    logic [NUM_BIT:0]   trial_diff;
    logic               trial_bout;
    logic               accept;
    logic [NUM_BIT-1:0] pr_next;

    assign shifted = {pr_q, dvd_q[NUM_BIT-1]};

    sub_ripple_borrow_nbit #(
        .NUM_BIT(NUM_BIT + 1)
    ) u_sub (
        .a   (shifted),
        .b   ({1'b0, dvs_q}),
        .bin (1'b0),
        .diff(trial_diff),
        .bout(trial_bout)
    );

    // The difference MSB is always zero when no borrow occurs.
    assign accept  = ~trial_bout & ~trial_diff[NUM_BIT];
    assign pr_next = accept ? trial_diff[NUM_BIT-1:0] : shifted[NUM_BIT-1:0];

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        cnt_d       = cnt_q;
        pr_d        = pr_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        pr_d    = '0;
                        cnt_d   = '0;
                    end
`else
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    pr_d    = '0;
                    cnt_d   = '0;
`endif
                end
            end
            S_RUN: begin
                pr_d  = pr_next;
                dvd_d = {dvd_q[NUM_BIT-2:0], accept};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cnt_d       = '0;
                    quotient_d  = {dvd_q[NUM_BIT-2:0], accept};
                    remainder_d = pr_next;
                    dbz_d       = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            cnt_q       <= '0;
            pr_q        <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            cnt_q       <= cnt_d;
            pr_q        <= pr_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_div_nbit.sv
// Self-checking bench for seq_restoring_div_nbit (NUM_BIT=8): directed cases from the
// test plan plus random operands checked against plain / and % arithmetic.

module tb_seq_restoring_div_nbit;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_div_nbit #(.NUM_BIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic; divide-by-zero yields all ones / dividend.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] eq, er, q0, r0;
        logic       edbz, held;
        int         lat, exp_lat, busy_cnt;
        eq      = (b == 0) ? 8'hFF : a / b;
        er      = (b == 0) ? a : a % b;
        edbz    = 1'b0;
        exp_lat = 9;
`ifdef DIV_ZERO_CHECK_EN
        if (b == 0) begin
            edbz    = 1'b1;
            exp_lat = 1;
        end
`endif
        q0   = quotient;
        r0   = remainder;
        held = 1'b1;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cnt++;
            if (quotient !== q0 || remainder !== r0) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        $display("op %s: %0d/%0d -> q=%0d r=%0d dbz=%0d latency=%0d (expect q=%0d r=%0d)",
                 tag, a, b, quotient, remainder, div_by_zero, lat, eq, er);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, (exp_lat == 1) ? 0 : 8);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_div_by_zero"}, div_by_zero, edbz);
        chk({tag, "_hold_during_run"}, held, 1'b1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int         n_done;
        int         first_idx, last_idx;
        logic [7:0] a, b, q_seen, r_seen;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        $display("reset: busy=%0d done=%0d q=%0d r=%0d dbz=%0d", busy, done, quotient, remainder, div_by_zero);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        rst = 1'b0;

        run_op(8'd100, 8'd7, "100/7");
        run_op(8'd255, 8'd1, "255/1");
        run_op(8'd5, 8'd9, "5/9");
        repeat (3) @(negedge clk);
        $display("hold after 5/9: q=%0d r=%0d", quotient, remainder);
        chk("hold_quotient", quotient, 0);
        chk("hold_remainder", remainder, 5);
        run_op(8'd200, 8'd0, "200/0");

        // start while busy must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;
        n_done = 0; q_seen = '0; r_seen = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
            if (done) begin
                n_done++;
                q_seen = quotient;
                r_seen = remainder;
            end
        end
        $display("ignore-start: dones=%0d q=%0d r=%0d", n_done, q_seen, r_seen);
        chk("ignore_done_count", n_done, 1);
        chk("ignore_quotient", q_seen, 14);
        chk("ignore_remainder", r_seen, 2);

        // reset during the 4th RUN cycle
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-run reset: busy=%0d done=%0d q=%0d r=%0d", busy, done, quotient, remainder);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run_op(8'd9, 8'd4, "9/4");

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 8'd8;
        n_done = 0; first_idx = 0; last_idx = 0;
        for (int i = 1; i <= 40 && n_done < 3; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                $display("back-to-back done #%0d at cycle %0d: q=%0d r=%0d", n_done, i, quotient, remainder);
                chk("b2b_quotient", quotient, 9);
                chk("b2b_remainder", remainder, 5);
                if (n_done == 1) first_idx = i;
                else chk("b2b_spacing", i - last_idx, 10);
                last_idx = i;
                if (n_done == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", n_done, 3);
        chk("b2b_first_latency", first_idx, 9);
        repeat (3) @(negedge clk);
        chk("b2b_idle_after", busy, 0);

        for (int k = 0; k < 24; k++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(a, b, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
